// File: rtl/tsmall_poly_gen_pkg.sv
// ============================================================================
//  Module      : tsp_pkg
//  Description : Shared types, coefficient codes and helper function for the
//                SNTRUP ternary polynomial generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tsp_pkg;

    // Selects fixed-weight (SHORT) or independent ternary (SMALL) generation
    typedef enum logic {
        MODE_SHORT = 1'b0,
        MODE_SMALL = 1'b1
    } mode_e;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FILL    = 4'd1,
        ST_SH_DRAW = 4'd2,
        ST_SH_RDI  = 4'd3,
        ST_SH_RDJ  = 4'd4,
        ST_SH_WRI  = 4'd5,
        ST_SH_WRJ  = 4'd6,
        ST_SM_DRAW = 4'd7,
        ST_DONE    = 4'd8
    } state_e;

    // Two-bit ternary codes; sign-extended to the RAM word width on write
    typedef logic [1:0] coef_t;
    localparam coef_t COEF_POS  = 2'b01;
    localparam coef_t COEF_NEG  = 2'b11;
    localparam coef_t COEF_ZERO = 2'b00;

    // Ceiling log2, used to build the initial all-ones shuffle mask
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          n;
        v = 1;
        n = 0;
        while (v < value) begin
            v = v << 1;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tsmall_poly_gen_if.sv
// ============================================================================
//  Module      : tsmall_poly_gen_if
//  Description : Control, random-source and RAM bus of the polynomial
//                generator.
//                master : generator side (consumes randomness, drives RAM)
//                slave  : environment side (source, RAM, controller)
//  Ports       : start/mode (control), rand_data/rand_valid/rand_ready
//                (random stream), mem_* (synchronous RAM), busy/done/weight
//                (status)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tsmall_poly_gen_if #(
    parameter int ADDR_W = 11,
    parameter int COEF_W = 13,
    parameter int RAND_W = 32
) ();

    logic              start;
    logic              mode;
    logic [RAND_W-1:0] rand_data;
    logic              rand_valid;
    logic              rand_ready;
    logic [ADDR_W-1:0] mem_waddr;
    logic [COEF_W-1:0] mem_wdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_raddr;
    logic [COEF_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] weight;

    modport master (
        input  start, mode, rand_data, rand_valid, mem_rdata,
        output rand_ready, mem_waddr, mem_wdata, mem_we, mem_raddr,
               busy, done, weight
    );

    modport slave (
        output start, mode, rand_data, rand_valid, mem_rdata,
        input  rand_ready, mem_waddr, mem_wdata, mem_we, mem_raddr,
               busy, done, weight
    );

endinterface

`default_nettype wire

// File: rtl/tsmall_poly_gen_range_sampler.sv
// ============================================================================
//  Module      : tsp_range_sampler
//  Description : Fisher-Yates index unit. Holds the descending index i, the
//                rejection mask (smallest 2^n-1 >= i) and the accepted
//                partner index j.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                load_i          - set i = P-1 and the initial mask
//                draw_i          - a random word is consumed this cycle
//                step_i          - decrement i, narrowing the mask if needed
//                rand_i          - random word
//                accept_o        - (rand_i & mask) <= i
//                idx_o / sel_o   - current i / latched j
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tsp_range_sampler
    import tsp_pkg::*;
#(
    parameter int P      = 757,
    parameter int ADDR_W = 11,
    parameter int RAND_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              draw_i,
    input  logic              step_i,
    input  logic [RAND_W-1:0] rand_i,
    output logic              accept_o,
    output logic [ADDR_W-1:0] idx_o,
    output logic [ADDR_W-1:0] sel_o
);

    localparam logic [ADDR_W-1:0] c_mask_init = ADDR_W'((1 << clog2(P)) - 1);
    localparam logic [ADDR_W-1:0] c_idx_init  = ADDR_W'(P - 1);

    logic [ADDR_W-1:0] idx_q,  idx_d;
    logic [ADDR_W-1:0] mask_q, mask_d;
    logic [ADDR_W-1:0] sel_q,  sel_d;
    logic [RAND_W-1:0] w_cand;

    // Mask the full word so the comparison sees every bit above the mask as 0
    assign w_cand   = rand_i & RAND_W'(mask_q);
    assign accept_o = (w_cand <= RAND_W'(idx_q));
    assign idx_o    = idx_q;
    assign sel_o    = sel_q;

    always_comb begin
        idx_d  = idx_q;
        mask_d = mask_q;
        sel_d  = sel_q;
        if (load_i) begin
            idx_d  = c_idx_init;
            mask_d = c_mask_init;
        end else if (step_i) begin
            idx_d = idx_q - 1'b1;
            // Keep the mask the tightest 2^n-1 covering the new index
            if (idx_d == (mask_q >> 1)) begin
                mask_d = mask_q >> 1;
            end
        end
        if (draw_i && accept_o) begin
            sel_d = w_cand[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            mask_q <= '0;
            sel_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            mask_q <= mask_d;
            sel_q  <= sel_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tsmall_poly_gen.sv
// ============================================================================
//  Module      : tsmall_poly_gen
//  Description : SNTRUP ternary polynomial generator. SHORT mode writes W
//                nonzero +-1 coefficients then Fisher-Yates shuffles the RAM;
//                SMALL mode writes independent uniform {-1,0,+1} values.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - control, random stream, RAM and status signals
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tsmall_poly_gen
    import tsp_pkg::*;
#(
    parameter int P      = 757,
    parameter int W      = 286,
    parameter int COEF_W = 13,
    parameter int ADDR_W = 11,
    parameter int RAND_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    tsmall_poly_gen_if.master  bus
);

    localparam logic [ADDR_W-1:0] c_last_k = ADDR_W'(P - 1);
    localparam logic [ADDR_W:0]   c_weight = (ADDR_W+1)'(W);

    state_e            state_q;
    logic [ADDR_W-1:0] k_q;
    logic [ADDR_W-1:0] weight_q;
    logic [COEF_W-1:0] vi_q;
    logic              busy_q;
    logic              done_q;

    logic              w_accept;
    logic [ADDR_W-1:0] w_idx;
    logic [ADDR_W-1:0] w_sel;
    logic              w_load;
    logic              w_draw;
    logic              w_step;
    logic              w_k_lt_w;
    logic [1:0]        w_b;

    function automatic logic [COEF_W-1:0] sext(input coef_t c);
        return {{(COEF_W-2){c[1]}}, c};
    endfunction

    assign w_k_lt_w = ({1'b0, k_q} < c_weight);
    assign w_b      = bus.rand_data[1:0];
    assign w_load   = (state_q == ST_FILL) && bus.rand_valid && (k_q == c_last_k);
    assign w_draw   = (state_q == ST_SH_DRAW) && bus.rand_valid;
    assign w_step   = (state_q == ST_SH_WRJ);

    tsp_range_sampler #(
        .P      (P),
        .ADDR_W (ADDR_W),
        .RAND_W (RAND_W)
    ) u_sampler (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (w_load),
        .draw_i   (w_draw),
        .step_i   (w_step),
        .rand_i   (bus.rand_data),
        .accept_o (w_accept),
        .idx_o    (w_idx),
        .sel_o    (w_sel)
    );

    // Control FSM. busy/done are registered so busy falls exactly as done rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            weight_q <= '0;
            vi_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        k_q      <= '0;
                        weight_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= (mode_e'(bus.mode) == MODE_SMALL) ? ST_SM_DRAW : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (bus.rand_valid) begin
                        if (w_k_lt_w) begin
                            weight_q <= weight_q + 1'b1;
                        end
                        if (k_q == c_last_k) begin
                            // A one-coefficient polynomial has nothing to shuffle
                            if (P == 1) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                state_q <= ST_SH_DRAW;
                            end
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                ST_SH_DRAW: begin
                    if (bus.rand_valid && w_accept) begin
                        state_q <= ST_SH_RDI;
                    end
                end
                ST_SH_RDI: state_q <= ST_SH_RDJ;
                ST_SH_RDJ: begin
                    vi_q    <= bus.mem_rdata;
                    state_q <= ST_SH_WRI;
                end
                ST_SH_WRI: state_q <= ST_SH_WRJ;
                ST_SH_WRJ: begin
                    // i is about to become i-1; finish once it reaches 0
                    if (w_idx == ADDR_W'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_SH_DRAW;
                    end
                end
                ST_SM_DRAW: begin
                    if (bus.rand_valid && (w_b != 2'b11)) begin
                        if (w_b != 2'b00) begin
                            weight_q <= weight_q + 1'b1;
                        end
                        if (k_q == c_last_k) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // RAM port decode. Fill/draw writes happen in the cycle the word is
    // consumed, so the write strobe follows rand_valid combinationally.
    always_comb begin
        bus.rand_ready = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_waddr  = '0;
        bus.mem_wdata  = '0;
        bus.mem_raddr  = '0;
        case (state_q)
            ST_FILL: begin
                bus.rand_ready = 1'b1;
                if (bus.rand_valid) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_waddr = k_q;
                    if (w_k_lt_w) begin
                        bus.mem_wdata = bus.rand_data[0] ? sext(COEF_NEG) : sext(COEF_POS);
                    end else begin
                        bus.mem_wdata = sext(COEF_ZERO);
                    end
                end
            end
            ST_SH_DRAW: bus.rand_ready = 1'b1;
            ST_SH_RDI:  bus.mem_raddr  = w_idx;
            ST_SH_RDJ:  bus.mem_raddr  = w_sel;
            ST_SH_WRI: begin
                bus.mem_we    = 1'b1;
                bus.mem_waddr = w_idx;
                bus.mem_wdata = bus.mem_rdata;
            end
            ST_SH_WRJ: begin
                bus.mem_we    = 1'b1;
                bus.mem_waddr = w_sel;
                bus.mem_wdata = vi_q;
            end
            ST_SM_DRAW: begin
                bus.rand_ready = 1'b1;
                if (bus.rand_valid && (w_b != 2'b11)) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_waddr = k_q;
                    case (w_b)
                        2'b01:   bus.mem_wdata = sext(COEF_POS);
                        2'b10:   bus.mem_wdata = sext(COEF_NEG);
                        default: bus.mem_wdata = sext(COEF_ZERO);
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.weight = weight_q;

endmodule

`default_nettype wire

// File: tb/tb_tsmall_poly_gen.sv
// ============================================================================
//  Module      : tb_tsmall_poly_gen
//  Description : Self-checking bench for tsmall_poly_gen. A small instance
//                (P=8, W=3) and a full-size instance (P=757, W=286) share the
//                random stream; an array-based reference model computes the
//                expected polynomial, weight, latency and words consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tsmall_poly_gen;

    localparam int ADDR_W = 11;
    localparam int COEF_W = 13;
    localparam int RAND_W = 32;
    localparam int PS = 8;
    localparam int WS = 3;
    localparam int PB = 757;
    localparam int WB = 286;
    localparam int DEPTH = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start_s, start_b, tb_mode, tb_valid, sel;
    logic [RAND_W-1:0] tb_data;

    tsmall_poly_gen_if #(.ADDR_W(ADDR_W), .COEF_W(COEF_W), .RAND_W(RAND_W)) if_s ();
    tsmall_poly_gen_if #(.ADDR_W(ADDR_W), .COEF_W(COEF_W), .RAND_W(RAND_W)) if_b ();

    tsmall_poly_gen #(.P(PS), .W(WS), .COEF_W(COEF_W), .ADDR_W(ADDR_W), .RAND_W(RAND_W))
        dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s.master));
    tsmall_poly_gen #(.P(PB), .W(WB), .COEF_W(COEF_W), .ADDR_W(ADDR_W), .RAND_W(RAND_W))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.master));

    // Synchronous RAMs, read data valid one cycle after the address
    logic [COEF_W-1:0] ram_s [0:DEPTH-1];
    logic [COEF_W-1:0] ram_b [0:DEPTH-1];
    logic [COEF_W-1:0] rd_s, rd_b;
    always @(posedge clk) begin
        if (if_s.mem_we) ram_s[if_s.mem_waddr] <= if_s.mem_wdata;
        rd_s <= ram_s[if_s.mem_raddr];
        if (if_b.mem_we) ram_b[if_b.mem_waddr] <= if_b.mem_wdata;
        rd_b <= ram_b[if_b.mem_raddr];
    end

    assign if_s.start      = start_s;
    assign if_s.mode       = tb_mode;
    assign if_s.rand_data  = tb_data;
    assign if_s.rand_valid = tb_valid;
    assign if_s.mem_rdata  = rd_s;
    assign if_b.start      = start_b;
    assign if_b.mode       = tb_mode;
    assign if_b.rand_data  = tb_data;
    assign if_b.rand_valid = tb_valid;
    assign if_b.mem_rdata  = rd_b;

    wire              w_ready  = sel ? if_b.rand_ready : if_s.rand_ready;
    wire              w_we     = sel ? if_b.mem_we     : if_s.mem_we;
    wire              w_busy   = sel ? if_b.busy       : if_s.busy;
    wire              w_done   = sel ? if_b.done       : if_s.done;
    wire [ADDR_W-1:0] w_weight = sel ? if_b.weight     : if_s.weight;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_viol = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // ---------------- reference model ----------------
    logic [RAND_W-1:0] words[$];
    int exp_c [0:PB-1];
    int exp_wt, exp_lat, exp_used;
    int obs_lat, obs_wt;

    task automatic ref_model(input bit md, input int p, input int w);
        int n, m, j, t, k;
        logic [1:0] b;
        n = 0;
        exp_lat = 0;
        if (md == 1'b0) begin
            for (int q = 0; q < p; q++) begin
                exp_c[q] = (q < w) ? (words[n][0] ? -1 : 1) : 0;
                n++;
            end
            exp_lat = p;
            for (int i = p - 1; i >= 1; i--) begin
                m = 1;
                while (m < i) m = m * 2 + 1;
                j = int'(words[n] & RAND_W'(m));
                n++;
                exp_lat++;
                while (j > i) begin
                    j = int'(words[n] & RAND_W'(m));
                    n++;
                    exp_lat++;
                end
                t = exp_c[i];
                exp_c[i] = exp_c[j];
                exp_c[j] = t;
                exp_lat += 4;
            end
        end else begin
            k = 0;
            while (k < p) begin
                b = words[n][1:0];
                n++;
                exp_lat++;
                if (b != 2'b11) begin
                    exp_c[k] = (b == 2'b00) ? 0 : (b == 2'b01) ? 1 : -1;
                    k++;
                end
            end
        end
        exp_lat++;
        exp_used = n;
        exp_wt = 0;
        for (int q = 0; q < p; q++) if (exp_c[q] != 0) exp_wt++;
    endtask

    task automatic gen_words(input bit rnd, input int cnt);
        words.delete();
        for (int i = 0; i < cnt; i++) words.push_back(rnd ? RAND_W'($urandom()) : '0);
    endtask

    // ---------------- run one polynomial ----------------
    task automatic run_poly(input bit big, input bit md, input bit toggle, input bit restart, input string tag);
        int p, w, c, n, nbad, nz;
        bit fire, got;
        logic [COEF_W-1:0] v, e;
        p = big ? PB : PS;
        w = big ? WB : WS;
        sel = big;
        ref_model(md, p, w);
        tb_mode  = md;
        tb_valid = 1'b0;
        @(posedge clk); #1;
        if (big) start_b = 1'b1; else start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        start_b = 1'b0;
        c = 1; n = 0; got = 1'b0;
        while (!got && c <= 20000) begin
            tb_valid = toggle ? c[0] : 1'b1;
            tb_data  = (n < words.size()) ? words[n] : '0;
            if (restart && c == 3) begin
                if (big) start_b = 1'b1; else start_s = 1'b1;
            end
            @(negedge clk);
            if (!tb_valid && w_ready && w_we) stall_viol++;
            if (w_done) begin
                got = 1'b1;
            end else begin
                fire = tb_valid && w_ready;
                @(posedge clk); #1;
                if (fire) n++;
                start_s = 1'b0;
                start_b = 1'b0;
                c++;
            end
        end
        tb_valid = 1'b0;
        check_value({tag, "_timeout"}, 64'(got), 64'd1);
        obs_lat = c;
        obs_wt  = int'(w_weight);
        if (!toggle) check_value({tag, "_latency"}, 64'(c), 64'(exp_lat));
        check_value({tag, "_weight"}, 64'(w_weight), 64'(exp_wt));
        check_value({tag, "_busy_at_done"}, 64'(w_busy), 64'd0);
        check_value({tag, "_consumed"}, 64'(n), 64'(exp_used));
        nbad = 0; nz = 0;
        for (int k = 0; k < p; k++) begin
            v = big ? ram_b[k] : ram_s[k];
            e = (exp_c[k] == 1) ? COEF_W'(1) : (exp_c[k] == -1) ? {COEF_W{1'b1}} : '0;
            if (v !== e) nbad++;
            if (v !== '0) nz++;
        end
        check_value({tag, "_ram"}, 64'(nbad), 64'd0);
        if (md == 1'b0) check_value({tag, "_nonzeros"}, 64'(nz), 64'(w));
        @(negedge clk);
        check_value({tag, "_done_pulse"}, 64'(w_done), 64'd0);
        @(negedge clk);
        check_value({tag, "_idle_busy"}, 64'(w_busy), 64'd0);
        check_value({tag, "_weight_hold"}, 64'(w_weight), 64'(exp_wt));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_busy"},  64'({if_s.busy, if_b.busy}), 64'd0);
        check_value({tag, "_done"},  64'({if_s.done, if_b.done}), 64'd0);
        check_value({tag, "_weight"}, 64'({if_s.weight, if_b.weight}), 64'd0);
        check_value({tag, "_ready"}, 64'({if_s.rand_ready, if_b.rand_ready}), 64'd0);
        check_value({tag, "_we"},    64'({if_s.mem_we, if_b.mem_we}), 64'd0);
        check_value({tag, "_addr"},  64'({if_s.mem_waddr, if_s.mem_raddr, if_b.mem_waddr, if_b.mem_raddr}), 64'd0);
        check_value({tag, "_wdata"}, 64'({if_s.mem_wdata, if_b.mem_wdata}), 64'd0);
    endtask

    initial begin
        start_s = 1'b0; start_b = 1'b0; tb_mode = 1'b0;
        tb_valid = 1'b0; tb_data = '0; sel = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #2 rst_n = 1'b1;

        // Abort in SH_DRAW: fill 8 words, then stall the source
        sel = 1'b0; tb_mode = 1'b0; tb_data = 32'h1; tb_valid = 1'b1;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        repeat (8) @(posedge clk);
        #1 tb_valid = 1'b0;
        @(negedge clk);
        check_value("pre_abort_ready", 64'(if_s.rand_ready), 64'd1);
        check_value("pre_abort_weight", 64'(if_s.weight), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #2 rst_n = 1'b1;

        // SHORT with all-zero words: every draw gives j=0
        gen_words(1'b0, 64);
        run_poly(1'b0, 1'b0, 1'b0, 1'b0, "short_zero");
        check_value("short_zero_lat_abs", 64'(obs_lat), 64'd44);
        check_value("short_zero_pos7", 64'(ram_s[7]), 64'd1);
        check_value("short_zero_pos2", 64'(ram_s[2]), 64'd0);

        // SMALL with two rejections
        words = {32'h13, 32'h20, 32'h41, 32'h72, 32'h05, 32'hF4, 32'h06, 32'h0B, 32'h11, 32'h30};
        run_poly(1'b0, 1'b1, 1'b0, 1'b0, "small_seq");
        check_value("small_seq_wt_abs", 64'(obs_wt), 64'd5);
        check_value("small_seq_lat_abs", 64'(obs_lat), 64'd11);

        // SHORT rejection: at i=4 (mask 7) words 7,5 rejected, 3 accepted
        words = {32'h1, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0,
                 32'h2, 32'h6, 32'h1, 32'h7, 32'h5, 32'h3, 32'h1, 32'h2, 32'h0};
        run_poly(1'b0, 1'b0, 1'b0, 1'b0, "short_rej");
        check_value("short_rej_lat_abs", 64'(obs_lat), 64'd46);

        for (int r = 0; r < 4; r++) begin
            gen_words(1'b1, 200);
            run_poly(1'b0, 1'b0, 1'b0, 1'b0, "short_rnd");
            gen_words(1'b1, 200);
            run_poly(1'b0, 1'b1, 1'b0, 1'b0, "small_rnd");
        end

        // Stalling source plus a start pulse while busy
        gen_words(1'b1, 200);
        run_poly(1'b0, 1'b0, 1'b1, 1'b1, "short_stall");
        run_poly(1'b0, 1'b0, 1'b0, 1'b0, "short_nostall");
        gen_words(1'b1, 200);
        run_poly(1'b0, 1'b1, 1'b1, 1'b1, "small_stall");

        // Full-size instance
        for (int r = 0; r < 2; r++) begin
            gen_words(1'b1, 4000);
            run_poly(1'b1, 1'b0, 1'b0, 1'b0, "big_short");
        end
        gen_words(1'b1, 2000);
        run_poly(1'b1, 1'b1, 1'b0, 1'b0, "big_small");

        check_value("stall_write", 64'(stall_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
